// File: rtl/meas_bcd_conv.sv
// meas_bcd_conv
// Periodically (or on request) snapshots the parameter-measurement results,
// scales the ADC codes (Vpp/max/min) to millivolts and converts all four
// values to packed BCD using one shared sequential double-dabble engine.
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   rst_n        : asynchronous active-low reset
//   refresh_req  : single-cycle request for an immediate conversion
//   ad_freq      : measured frequency in Hz (clk domain)
//   ad_vpp/max/min : 8-bit ADC codes from another clock domain, quasi-static
//   freq_bcd     : 7 BCD digits, most significant digit in [27:24]
//   vpp/max/min_bcd : 4 BCD digits of millivolts
//   meas_unstable: result set was captured without two matching samples
//   bcd_valid    : one-cycle strobe, every BCD output updated this cycle
//   busy         : high whenever the controller is not idle
//
// Handshake: there is no back-pressure. bcd_valid is a pure strobe; the
// outputs hold their value between strobes, so a consumer may latch on the
// strobe or read at any later time.
module meas_bcd_conv #(
  parameter logic [24:0] REFRESH_CYC = 25'd5_000_000,
  parameter logic [13:0] VFS_MV      = 14'd10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh_req,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_vpp,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min,
  output logic [27:0] freq_bcd,
  output logic [15:0] vpp_bcd,
  output logic [15:0] max_bcd,
  output logic [15:0] min_bcd,
  output logic        meas_unstable,
  output logic        bcd_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMP0, S_SAMP1, S_SCALE, S_CONV, S_DONE
  } state_e;

  localparam logic [24:0] REF_LAST = REFRESH_CYC - 25'd1;
  localparam logic [4:0]  DD_STORE = 5'd21;  // load + 20 shifts, then store

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [1:0]  retry_q, retry_d;
  logic [24:0] ref_cnt_q;

  logic [7:0]  s1_vpp_q, s1_max_q, s1_min_q;
  logic [19:0] freq_q;
  logic        unstable_q;
  logic [13:0] mv_vpp_q, mv_max_q, mv_min_q;

  logic [19:0] dd_bin_q;
  logic [27:0] dd_bcd_q;
  logic [4:0]  dd_cyc_q;
  logic [1:0]  dd_sel_q;
  logic [27:0] st_freq_q;
  logic [15:0] st_vpp_q, st_max_q;

  logic [27:0] freq_bcd_q;
  logic [15:0] vpp_bcd_q, max_bcd_q, min_bcd_q;
  logic        meas_unstable_q, bcd_valid_q;

  logic        tick, req, samp_diff, dd_last;
  logic [19:0] dd_operand;
  logic [27:0] dd_adj;

  // Tick and refresh_req in the same cycle collapse into one request.
  assign tick      = (ref_cnt_q == REF_LAST);
  assign req       = tick | refresh_req;
  assign samp_diff = (ad_vpp != s1_vpp_q) || (ad_max != s1_max_q) ||
                     (ad_min != s1_min_q);
  assign dd_last   = (dd_cyc_q == DD_STORE) && (dd_sel_q == 2'd3);

  // Operand order: freq, vpp, max, min. mV values are zero-extended.
  always_comb begin
    dd_operand = freq_q;
    case (dd_sel_q)
      2'd1:    dd_operand = {6'd0, mv_vpp_q};
      2'd2:    dd_operand = {6'd0, mv_max_q};
      2'd3:    dd_operand = {6'd0, mv_min_q};
      default: dd_operand = freq_q;
    endcase
  end

  // Add-3 correction on every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    dd_adj = dd_bcd_q;
    for (int i = 0; i < 7; i++) begin
      if (dd_bcd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Controller: next state, pending flag and retry counter.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    retry_d   = retry_q;
    // A request arriving while busy (including the DONE cycle) is remembered
    // once; any further requests before the restart are dropped.
    if (state_q != S_IDLE && req) pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req || pending_q) begin
          state_d   = S_SAMP0;
          pending_d = 1'b0;
        end
      end
      S_SAMP0: begin
        retry_d = 2'd0;
        state_d = S_SAMP1;
      end
      S_SAMP1: begin
        if (!samp_diff || retry_q == 2'd3) begin
          state_d = S_SCALE;
          retry_d = 2'd0;
        end else begin
          retry_d = retry_q + 2'd1;
        end
      end
      S_SCALE: state_d = S_CONV;
      S_CONV:  if (dd_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      retry_q   <= 2'd0;
      ref_cnt_q <= 25'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      retry_q   <= retry_d;
      ref_cnt_q <= tick ? 25'd0 : ref_cnt_q + 25'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vpp_q <= 8'd0;  s1_max_q <= 8'd0;  s1_min_q <= 8'd0;
      freq_q   <= 20'd0; unstable_q <= 1'b0;
      mv_vpp_q <= 14'd0; mv_max_q <= 14'd0; mv_min_q <= 14'd0;
      dd_bin_q <= 20'd0; dd_bcd_q <= 28'd0; dd_cyc_q <= 5'd0; dd_sel_q <= 2'd0;
      st_freq_q <= 28'd0; st_vpp_q <= 16'd0; st_max_q <= 16'd0;
      freq_bcd_q <= 28'd0; vpp_bcd_q <= 16'd0; max_bcd_q <= 16'd0;
      min_bcd_q  <= 16'd0; meas_unstable_q <= 1'b0; bcd_valid_q <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        S_SAMP0: begin
          s1_vpp_q <= ad_vpp; s1_max_q <= ad_max; s1_min_q <= ad_min;
        end
        S_SAMP1: begin
          // Reload on mismatch; on exit this same load is the accepted value.
          s1_vpp_q <= ad_vpp; s1_max_q <= ad_max; s1_min_q <= ad_min;
          if (state_d == S_SCALE) begin
            freq_q     <= ad_freq;
            unstable_q <= samp_diff;
          end
        end
        S_SCALE: begin
          // 8-bit code x 14-bit span = 22-bit product; keep bits [21:8].
          mv_vpp_q <= 14'((22'(s1_vpp_q) * 22'(VFS_MV)) >> 8);
          mv_max_q <= 14'((22'(s1_max_q) * 22'(VFS_MV)) >> 8);
          mv_min_q <= 14'((22'(s1_min_q) * 22'(VFS_MV)) >> 8);
          dd_cyc_q <= 5'd0;
          dd_sel_q <= 2'd0;
        end
        S_CONV: begin
          if (dd_cyc_q == 5'd0) begin
            dd_bin_q <= dd_operand;
            dd_bcd_q <= 28'd0;
            dd_cyc_q <= dd_cyc_q + 5'd1;
          end else if (dd_cyc_q != DD_STORE) begin
            dd_bcd_q <= {dd_adj[26:0], dd_bin_q[19]};
            dd_bin_q <= {dd_bin_q[18:0], 1'b0};
            dd_cyc_q <= dd_cyc_q + 5'd1;
          end else begin
            case (dd_sel_q)
              2'd0:    st_freq_q <= dd_bcd_q;
              2'd1:    st_vpp_q  <= dd_bcd_q[15:0];
              2'd2:    st_max_q  <= dd_bcd_q[15:0];
              default: ;
            endcase
            dd_sel_q <= dd_sel_q + 2'd1;
            dd_cyc_q <= 5'd0;
          end
          // The final store edge also loads the outputs (min bypasses the
          // staging register), so every output and the strobe become
          // visible together in the DONE cycle.
          if (dd_last) begin
            freq_bcd_q      <= st_freq_q;
            vpp_bcd_q       <= st_vpp_q;
            max_bcd_q       <= st_max_q;
            min_bcd_q       <= dd_bcd_q[15:0];
            meas_unstable_q <= unstable_q;
            bcd_valid_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign freq_bcd      = freq_bcd_q;
  assign vpp_bcd       = vpp_bcd_q;
  assign max_bcd       = max_bcd_q;
  assign min_bcd       = min_bcd_q;
  assign meas_unstable = meas_unstable_q;
  assign bcd_valid     = bcd_valid_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_meas_bcd_conv.sv
module tb_meas_bcd_conv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;  // index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // A: requests only (refresh never ticks), B: REFRESH 128, C: periodic 200/5000
  logic        rst_a, rst_b, rst_c;
  logic        req_a, req_b, req_c;
  logic [19:0] freq_a, freq_b, freq_c;
  logic [7:0]  vpp_a, max_a, min_a, vpp_b, max_b, min_b, vpp_c, max_c, min_c;
  logic [27:0] fbcd_a, fbcd_b, fbcd_c;
  logic [15:0] vbcd_a, xbcd_a, nbcd_a, vbcd_b, xbcd_b, nbcd_b, vbcd_c, xbcd_c, nbcd_c;
  logic        unst_a, unst_b, unst_c, valid_a, valid_b, valid_c, busy_a, busy_b, busy_c;

  meas_bcd_conv #(.REFRESH_CYC(25'h1FF_FFFF), .VFS_MV(14'd10000)) u_a (
    .clk(clk), .rst_n(rst_a), .refresh_req(req_a), .ad_freq(freq_a),
    .ad_vpp(vpp_a), .ad_max(max_a), .ad_min(min_a),
    .freq_bcd(fbcd_a), .vpp_bcd(vbcd_a), .max_bcd(xbcd_a), .min_bcd(nbcd_a),
    .meas_unstable(unst_a), .bcd_valid(valid_a), .busy(busy_a));

  meas_bcd_conv #(.REFRESH_CYC(25'd128), .VFS_MV(14'd10000)) u_b (
    .clk(clk), .rst_n(rst_b), .refresh_req(req_b), .ad_freq(freq_b),
    .ad_vpp(vpp_b), .ad_max(max_b), .ad_min(min_b),
    .freq_bcd(fbcd_b), .vpp_bcd(vbcd_b), .max_bcd(xbcd_b), .min_bcd(nbcd_b),
    .meas_unstable(unst_b), .bcd_valid(valid_b), .busy(busy_b));

  meas_bcd_conv #(.REFRESH_CYC(25'd200), .VFS_MV(14'd5000)) u_c (
    .clk(clk), .rst_n(rst_c), .refresh_req(req_c), .ad_freq(freq_c),
    .ad_vpp(vpp_c), .ad_max(max_c), .ad_min(min_c),
    .freq_bcd(fbcd_c), .vpp_bcd(vbcd_c), .max_bcd(xbcd_c), .min_bcd(nbcd_c),
    .meas_unstable(unst_c), .bcd_valid(valid_c), .busy(busy_c));

  // Strobe times of the free-running periodic instance.
  int unsigned c_valid_q[$];
  always @(negedge clk) if (valid_c) c_valid_q.push_back(cyc);

  // ---------------- reference model ----------------
  function automatic logic [31:0] to_bcd(input int unsigned v, input int digits);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned to_mv(input int unsigned code, input int unsigned vfs);
    return (code * vfs) / 256;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_req_a(output int unsigned k);
    @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    k = cyc;
  endtask

  task automatic wait_valid_a(input int unsigned k, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_a) begin
        lat = int'(cyc - k);
        break;
      end
    end
  endtask

  task automatic run_overlap(input int o1, input int o2, input string tag);
    int unsigned k;
    int vq[$];
    int idle;
    idle = 0;
    pulse_req_a(k);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (valid_a) vq.push_back(int'(cyc - k));
      if (!busy_a && vq.size() == 1) idle++;
      req_a = ((cyc - k) == o1 - 1) || ((cyc - k) == o2 - 1);
    end
    req_a = 1'b0;
    check_eq({tag, "_nvalid"}, vq.size(), 2);
    if (vq.size() == 2) begin
      check_eq({tag, "_lat1"}, vq[0], 91);
      check_eq({tag, "_lat2"}, vq[1], 184);
    end
    check_eq({tag, "_idle_gap"}, idle, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_q[$];

  initial begin
    int unsigned r, r2, k;
    int lat, viol;
    int unsigned tog_code;
    rst_a = 0; rst_b = 0; rst_c = 0;
    req_a = 0; req_b = 0; req_c = 0;
    freq_a = 0; vpp_a = 0; max_a = 0; min_a = 0;
    freq_b = 20'd12345; vpp_b = 8'd100; max_b = 8'd150; min_b = 8'd20;
    freq_c = 20'd50;    vpp_c = 8'd128; max_c = 8'd255; min_c = 8'd1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_b, 0);
    check_eq("rst_valid", valid_b, 0);
    check_eq("rst_freq", fbcd_b, 0);
    check_eq("rst_vpp", vbcd_b, 0);
    rst_a = 1; rst_b = 1; rst_c = 1;
    r = cyc;

    // B: nothing happens for 127 cycles after release, then the first tick run
    viol = 0;
    repeat (127) begin
      @(negedge clk);
      if (busy_b || valid_b || fbcd_b != 0 || vbcd_b != 0 || xbcd_b != 0 ||
          nbcd_b != 0 || unst_b) viol++;
    end
    check_eq("quiet_127", viol, 0);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_b) begin lat = int'(cyc - r); break; end
    end
    check_eq("tick_first_lat", lat, 219);
    check_eq("tick_freq", fbcd_b, to_bcd(12345, 7));
    check_eq("tick_vpp", vbcd_b, to_bcd(to_mv(100, 10000), 4));
    check_eq("tick_max", xbcd_b, to_bcd(to_mv(150, 10000), 4));
    check_eq("tick_min", nbcd_b, to_bcd(to_mv(20, 10000), 4));
    check_eq("tick_unst", unst_b, 0);

    // B: reset 50 cycles into the next periodic run
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_b) begin lat = 0; break; end
    end
    check_eq("second_run_start", lat, 0);
    repeat (50) @(negedge clk);
    rst_b = 0;
    #1;
    check_eq("midrst_busy", busy_b, 0);
    check_eq("midrst_freq", fbcd_b, 0);
    check_eq("midrst_vpp", vbcd_b, 0);
    check_eq("midrst_min", nbcd_b, 0);
    repeat (2) @(negedge clk);
    check_eq("midrst_valid", valid_b, 0);
    rst_b = 1;
    r2 = cyc;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_b) begin lat = int'(cyc - r2); break; end
    end
    check_eq("midrst_resume_lat", lat, 219);

    // A: full-scale directed case
    freq_a = 20'd1048575; vpp_a = 8'd255; max_a = 8'd200; min_a = 8'd0;
    pulse_req_a(k);
    wait_valid_a(k, 120, lat);
    check_eq("fs_lat", lat, 91);
    check_eq("fs_freq", fbcd_a, 32'h1048575);
    check_eq("fs_vpp", vbcd_a, 32'h9960);
    check_eq("fs_max", xbcd_a, 32'h7812);
    check_eq("fs_min", nbcd_a, 32'h0000);
    check_eq("fs_unst", unst_a, 0);

    // A: Vpp toggling every cycle exhausts the retries
    max_a = 8'd64; min_a = 8'd3; freq_a = 20'd777;
    k = 0; lat = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (k != 0 && valid_a && lat < 0) lat = int'(cyc - k);
      vpp_a = (cyc % 2 != 0) ? 8'd11 : 8'd10;
      if (i == 2) begin req_a = 1'b1; k = cyc + 1; end
      else req_a = 1'b0;
    end
    // Accepted code is the one present at the SAMP1 exit edge, k+5.
    tog_code = ((k + 4) % 2 != 0) ? 11 : 10;
    check_eq("unst_lat", lat, 94);
    check_eq("unst_flag", unst_a, 1);
    check_eq("unst_vpp", vbcd_a, to_bcd(to_mv(tog_code, 10000), 4));
    check_eq("unst_max", xbcd_a, to_bcd(to_mv(64, 10000), 4));
    check_eq("unst_freq", fbcd_a, to_bcd(777, 7));
    vpp_a = 8'd10;

    // A: requests while busy collapse into one pending run
    run_overlap(10, 20, "ovl");
    run_overlap(91, 92, "ovl_done");

    // A: random snapshots through the scoreboard
    for (int it = 0; it < 8; it++) begin
      freq_a = 20'($urandom_range(0, 1048575));
      vpp_a  = 8'($urandom_range(0, 255));
      max_a  = 8'($urandom_range(0, 255));
      min_a  = 8'($urandom_range(0, 255));
      exp_q.push_back(to_bcd(freq_a, 7));
      exp_q.push_back(to_bcd(to_mv(vpp_a, 10000), 4));
      exp_q.push_back(to_bcd(to_mv(max_a, 10000), 4));
      exp_q.push_back(to_bcd(to_mv(min_a, 10000), 4));
      pulse_req_a(k);
      wait_valid_a(k, 120, lat);
      check_eq("rnd_lat", lat, 91);
      check_eq("rnd_freq", fbcd_a, exp_q.pop_front());
      check_eq("rnd_vpp", vbcd_a, exp_q.pop_front());
      check_eq("rnd_max", xbcd_a, exp_q.pop_front());
      check_eq("rnd_min", nbcd_a, exp_q.pop_front());
      check_eq("rnd_unst", unst_a, 0);
    end

    // C: periodic runs every 200 cycles with VFS 5000
    check_eq("per_count_ge3", (c_valid_q.size() >= 3), 1);
    if (c_valid_q.size() >= 3) begin
      check_eq("per_first", c_valid_q[0] - r, 291);
      check_eq("per_gap1", c_valid_q[1] - c_valid_q[0], 200);
      check_eq("per_gap2", c_valid_q[2] - c_valid_q[1], 200);
    end
    check_eq("per_freq", fbcd_c, 32'h0000050);
    check_eq("per_vpp", vbcd_c, 32'h2500);
    check_eq("per_max", xbcd_c, to_bcd(to_mv(255, 5000), 4));
    check_eq("per_min", nbcd_c, to_bcd(to_mv(1, 5000), 4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/meas_bcd_conv.md
# meas_bcd_conv

Downstream consumer of the parameter-measurement outputs (frequency, Vpp, max, min) in the DSO datapath. Periodically snapshots the measurements, scales ADC codes to millivolts, and converts everything to packed BCD with a single shared sequential double-dabble engine. Feeds the on-screen text overlay and UART report blocks, which latch on `bcd_valid`.

## Interface
- `REFRESH_CYC`, 25'd5_000_000: refresh period in `clk` cycles (10 Hz at 50 MHz); legal range 128..2^25-1
- `VFS_MV`, 14'd10000: ADC full-scale span in mV; legal range 1..10000 (guarantees 4-digit results)
- `clk` input 1: system clock 50 MHz; all logic on rising edge
- `rst_n` input 1: system reset, active-low, asynchronous assert; one clock, no other clock domain inside the block
- `refresh_req` input 1: single-cycle request for an immediate conversion
- `ad_freq` input 20: measured frequency in Hz (`clk` domain)
- `ad_vpp`, `ad_max`, `ad_min` input 8 each: ADC codes, produced in `ad_clk` domain, quasi-static
- `freq_bcd` output 28: 7 BCD digits, MSD at [27:24]
- `vpp_bcd`, `max_bcd`, `min_bcd` output 16 each: 4 BCD digits of mV
- `meas_unstable` output 1: result set was captured without two matching samples
- `bcd_valid` output 1: one-cycle strobe, all BCD outputs updated this cycle
- `busy` output 1: high in every state except IDLE

## Operation
- Refresh counter free-runs 0..REFRESH_CYC-1; tick on terminal count. Tick or `refresh_req` = request.
- Request in IDLE starts a run. Request while busy sets `pending` (single bit; further requests dropped). On return to IDLE with `pending`=1, clear it and start a run next cycle.
- States: IDLE -> SAMP0 -> SAMP1 -> SCALE -> CONV -> DONE -> IDLE.
- SAMP0: capture `ad_vpp/max/min` into s1.
- SAMP1: compare live inputs with s1. Equal -> accept live values, `unstable`=0, go SCALE. Mismatch -> reload s1, retry_cnt+1, stay. Mismatch with retry_cnt==3 -> accept live values, `unstable`=1, go SCALE. `ad_freq` captured on exit from SAMP1.
- SCALE (1 cycle): mv = (code × VFS_MV) >> 8, 22-bit product, truncated, 14-bit result, ≤ 9999, for each of vpp/max/min.
- CONV: one 20-bit-in/28-bit-out double-dabble engine run 4 times in order freq, vpp, max, min. Each run: 1 load cycle + 20 shift cycles + 1 store cycle = 22; total 88. mV operands zero-extended to 20 bits; low 16 BCD bits stored.
- Add-3 correction on every nibble ≥ 5 before each shift.
- DONE: transfer all four staged results and `unstable` to outputs together, pulse `bcd_valid`.
- Outputs never change except in DONE; no partial update visible.
- `min > max` codes are converted as-is; no sanity correction.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, pending 0, retry_cnt 0.
- Reset asserted mid-run: run aborted immediately, no `bcd_valid`, outputs 0; after release, counter restarts from 0.
- Request sampled on edge k: SAMP0 from edge k; stable inputs -> outputs and `bcd_valid` registered on edge k+91; each SAMP1 retry adds 1 cycle (max k+94).
- `busy` high from edge k through the DONE cycle; low the cycle after DONE unless pending restarts.
- Request coincident with DONE cycle -> sets pending (block still busy).
- Tick and `refresh_req` in same cycle -> one request.
- REFRESH_CYC ≥ 128 ensures periodic runs never overlap; pending covers `refresh_req` overlap.

## Test plan
- Reset: hold `rst_n`=0 then release with no request -> all outputs 0, `busy`=0, no `bcd_valid` for 127 cycles with REFRESH_CYC=128.
- Full-scale: `ad_freq`=1048575, vpp=255, max=200, min=0, VFS_MV=10000, `refresh_req` at k -> `bcd_valid` at k+91, `freq_bcd`=0x1048575, `vpp_bcd`=0x9960, `max_bcd`=0x7812, `min_bcd`=0x0000, `meas_unstable`=0.
- Unstable: `ad_vpp` toggling 10/11 every cycle -> `bcd_valid` at k+94, `meas_unstable`=1, `vpp_bcd` matches live code at SAMP1 exit (10->0x0390, 11->0x0429).
- Overlap: `refresh_req` at k, k+10, k+20 -> exactly two `bcd_valid` (k+91, k+184), `busy` low only 1 cycle between.
- Mid-run reset: request at k, `rst_n`=0 at k+50 -> no `bcd_valid`, outputs 0; after release, periodic tick resumes after REFRESH_CYC cycles.
- Periodic: REFRESH_CYC=200, freq=50, vpp=128, VFS_MV=5000 -> `bcd_valid` every 200 cycles, `freq_bcd`=0x0000050, `vpp_bcd`=0x2500.
